// File: rtl/bicubic_weight_pipe_if.sv
// Tap-set input and weighted-result output bundle for bicubic_weight_pipe.
// master drives taps and out_ready; slave is the weighting unit.
interface bicubic_weight_pipe_if #(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 7
);
  localparam int IN_W  = PIX_W + FRAC_W;
  localparam int SUM_W = IN_W + 2;

  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              phase;
  logic [IN_W-1:0]         in_0;
  logic [IN_W-1:0]         in_1;
  logic [IN_W-1:0]         in_2;
  logic [IN_W-1:0]         in_3;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [SUM_W-1:0] weight_sum;
  logic [PIX_W-1:0]        pix_out;

  modport master (
    output in_valid, phase, in_0, in_1, in_2, in_3, out_ready,
    input  in_ready, out_valid, weight_sum, pix_out
  );

  modport slave (
    input  in_valid, phase, in_0, in_1, in_2, in_3, out_ready,
    output in_ready, out_valid, weight_sum, pix_out
  );
endinterface

// File: rtl/bicubic_weight_pipe.sv
// Four-stage Keys (a = -0.5) 4-tap weighting pipe: lookup, multiply, sum/round,
// then pixel round and clamp. One global enable stalls every stage together.
module bicubic_weight_pipe #(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  bicubic_weight_pipe_if.slave bus
);
  localparam int IN_W   = PIX_W + FRAC_W;
  localparam int SUM_W  = IN_W + 2;
  localparam int PROD_W = IN_W + 10;
  localparam int ACC_W  = IN_W + 12;
  localparam int HALF   = 1 << (FRAC_W - 1);
  localparam logic signed [SUM_W:0] PIX_MAX = (SUM_W+1)'((1 << PIX_W) - 1);

  // Rows indexed by phase, columns by tap p[-1]..p[2]; every row sums to 128.
  localparam logic signed [8:0] COEF [4][4] = '{
    '{ 9'sd0,   9'sd128, 9'sd0,   9'sd0  },
    '{-9'sd9,   9'sd111, 9'sd29, -9'sd3  },
    '{-9'sd8,   9'sd72,  9'sd72, -9'sd8  },
    '{-9'sd3,   9'sd29,  9'sd111,-9'sd9  }
  };

  logic                     en;
  logic [IN_W-1:0]          tap_in [4];

  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic [IN_W-1:0]          tap1_q [4];
  logic [IN_W-1:0]          tap1_d [4];
  logic signed [8:0]        coef1_q [4];
  logic signed [8:0]        coef1_d [4];
  logic signed [PROD_W-1:0] prod_w [4];
  logic signed [PROD_W-1:0] prod2_q [4];
  logic signed [PROD_W-1:0] prod2_d [4];
  logic signed [ACC_W-1:0]  acc_w;
  logic signed [ACC_W-1:0]  acc_rnd_w;
  logic signed [SUM_W-1:0]  ws3_q, ws3_d, ws4_q, ws4_d;
  logic signed [SUM_W:0]    r_sum_w;
  logic signed [SUM_W:0]    r_w;
  logic [PIX_W-1:0]         pix4_q, pix4_d;

  assign tap_in[0] = bus.in_0;
  assign tap_in[1] = bus.in_1;
  assign tap_in[2] = bus.in_2;
  assign tap_in[3] = bus.in_3;

  // Taps are unsigned; a zero MSB makes them positive before the signed multiply.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mul
    assign prod_w[gi] = PROD_W'($signed({1'b0, tap1_q[gi]})) * PROD_W'(coef1_q[gi]);
  end

  always_comb begin
    acc_w     = ACC_W'(prod2_q[0]) + ACC_W'(prod2_q[1]) + ACC_W'(prod2_q[2]) + ACC_W'(prod2_q[3]);
    acc_rnd_w = acc_w + ACC_W'(64);
    r_sum_w   = (SUM_W+1)'(ws3_q) + (SUM_W+1)'(HALF);
    r_w       = r_sum_w >>> FRAC_W;
  end

  always_comb begin
    en      = bus.out_ready || !v4_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    v4_d    = v4_q;
    tap1_d  = tap1_q;
    coef1_d = coef1_q;
    prod2_d = prod2_q;
    ws3_d   = ws3_q;
    ws4_d   = ws4_q;
    pix4_d  = pix4_q;
    if (en) begin
      v1_d = bus.in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      v4_d = v3_q;
      if (bus.in_valid) begin
        for (int i = 0; i < 4; i++) begin
          tap1_d[i]  = tap_in[i];
          coef1_d[i] = COEF[bus.phase][i];
        end
      end
      prod2_d = prod_w;
      ws3_d   = SUM_W'(acc_rnd_w >>> 7);
      ws4_d   = ws3_q;
      if (r_w < 0)
        pix4_d = '0;
      else if (r_w > PIX_MAX)
        pix4_d = PIX_MAX[PIX_W-1:0];
      else
        pix4_d = r_w[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      tap1_q  <= '{default: '0};
      coef1_q <= '{default: '0};
      prod2_q <= '{default: '0};
      ws3_q   <= '0;
      ws4_q   <= '0;
      pix4_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      v4_q    <= v4_d;
      tap1_q  <= tap1_d;
      coef1_q <= coef1_d;
      prod2_q <= prod2_d;
      ws3_q   <= ws3_d;
      ws4_q   <= ws4_d;
      pix4_q  <= pix4_d;
    end
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = v4_q;
  assign bus.weight_sum = ws4_q;
  assign bus.pix_out    = pix4_q;
endmodule
